anchor_scheduler: RTL



---
 rtl/anchor_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/anchor_scheduler.sv
// rtl/anchor_scheduler.sv - frame-level anchor sequencer for the blur stage
// Walks the anchor column-by-column, band-by-band; one fetch/filter handshake per position.
module anchor_scheduler #(
    parameter int X_BITS   = 10,
    parameter int Y_BITS   = 10,
    parameter int WIN      = 20,
    parameter int ROW_STEP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [X_BITS-1:0] img_width,
    input  logic [Y_BITS-1:0] img_height,
    input  logic              fetch_ack,
    input  logic              filter_final,
    output logic              fetch_req,
    output logic              anchor_moving,
    output logic [31:0]       anchor_x,
    output logic [31:0]       anchor_y,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);

    localparam int YW = Y_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT_FILT,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [X_BITS-1:0] ax_q, ax_d;
    logic [Y_BITS-1:0] ay_q, ay_d;
    logic [X_BITS-1:0] w_q, w_d;
    logic [Y_BITS-1:0] h_q, h_d;
    logic              err_q, err_d;

    logic [YW-1:0]     ay_next;
    logic              col_last;
    logic              band_end;

    // One extra bit so the next band's bottom edge is compared without wrapping.
    assign ay_next  = {1'b0, ay_q} + YW'(ROW_STEP);
    assign band_end = (ay_next + YW'(WIN)) > {1'b0, h_q};
    assign col_last = ax_q >= (w_q - X_BITS'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ax_q    <= '0;
            ay_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            w_q     <= w_d;
            h_q     <= h_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        w_d     = w_q;
        h_d     = h_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    w_d   = img_width;
                    h_d   = img_height;
                    ax_d  = '0;
                    ay_d  = '0;
                    err_d = 1'b0;
                    if (img_width == '0 || img_height < Y_BITS'(WIN)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH:     if (fetch_ack) state_d = S_START;
            S_START:     state_d = S_WAIT_FILT;
            S_WAIT_FILT: if (filter_final) state_d = S_ADVANCE;
            S_ADVANCE: begin
                if (!col_last) begin
                    ax_d    = ax_q + X_BITS'(1);
                    state_d = S_FETCH;
                end else if (band_end) begin
                    // Last band finished: leave coordinates on the final position.
                    state_d = S_DONE;
                end else begin
                    ax_d    = '0;
                    ay_d    = ay_next[Y_BITS-1:0];
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            ax_d    = ax_q;
            ay_d    = ay_q;
        end
    end

    assign fetch_req     = (state_q == S_FETCH);
    assign anchor_moving = (state_q == S_START);
    assign frame_done    = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign cfg_err       = err_q;
    assign anchor_x      = {{(32-X_BITS){1'b0}}, ax_q};
    assign anchor_y      = {{(32-Y_BITS){1'b0}}, ay_q};

endmodule
